// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the single-master FSM state type.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;
    localparam logic [1:0] HRESP_RETRY = 2'b10;
    localparam logic [1:0] HRESP_SPLIT = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef logic [1:0] state_t;
    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_ADDR = 2'd1;
    localparam state_t S_DATA = 2'd2;

endpackage

// File: rtl/ahb_single_master_errcnt.sv
// Saturating 16-bit error counter; clear wins over a same-cycle increment.
module ahb_single_master_errcnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    input  logic        clr,
    output logic [15:0] count
);

    logic [15:0] count_q;
    logic [15:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = 16'h0000;
        end else if (inc && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'h0001;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 16'h0000;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/ahb_single_master.sv
// AHB-Lite initiator: valid/ready commands become single non-pipelined transfers.
// Optional error counter is built when AHB_SINGLE_MASTER_ERRCNT_EN is defined.
module ahb_single_master
    import ahb_pkg::*;
#(
    parameter int         ADDR_WIDTH = 32,
    parameter int         DATA_WIDTH = 32,
    parameter logic [3:0] HPROT_VAL  = 4'b0011
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
`ifdef AHB_SINGLE_MASTER_ERRCNT_EN
    input  logic                  err_clr,
    output logic [15:0]           err_count,
`endif
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [2:0]            cmd_size,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic [1:0]            HTRANS,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic                  HMASTLOCK,
    output logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    input  logic [1:0]            HRESP,
    input  logic [DATA_WIDTH-1:0] HRDATA
);

    state_t                state_q,     state_d;
    logic [ADDR_WIDTH-1:0] haddr_q,     haddr_d;
    logic [1:0]            htrans_q,    htrans_d;
    logic                  hwrite_q,    hwrite_d;
    logic [2:0]            hsize_q,     hsize_d;
    logic [DATA_WIDTH-1:0] hwdata_q,    hwdata_d;
    logic [DATA_WIDTH-1:0] wdata_q,     wdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_error_q, rsp_error_d;

    // Held low during the response pulse so the next accept lands one cycle later.
    assign cmd_ready = (state_q == S_IDLE) && !rsp_valid_q;

    always_comb begin
        state_d     = state_q;
        haddr_d     = haddr_q;
        htrans_d    = htrans_q;
        hwrite_d    = hwrite_q;
        hsize_d     = hsize_q;
        hwdata_d    = hwdata_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    haddr_d  = cmd_addr;
                    hwrite_d = cmd_write;
                    hsize_d  = cmd_size;
                    wdata_d  = cmd_wdata;
                    htrans_d = HTRANS_NONSEQ;
                    state_d  = S_ADDR;
                end
            end
            S_ADDR: begin
                if (HREADY) begin
                    htrans_d = HTRANS_IDLE;
                    if (hwrite_q) begin
                        hwdata_d = wdata_q;
                    end
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                // First cycle of a two-cycle ERROR needs nothing: HTRANS is already IDLE.
                if (HREADY) begin
                    rsp_valid_d = 1'b1;
                    rsp_error_d = (HRESP != HRESP_OKAY);
                    if (!hwrite_q) begin
                        rsp_rdata_d = HRDATA;
                    end
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d  = S_IDLE;
                htrans_d = HTRANS_IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= S_IDLE;
            haddr_q     <= '0;
            htrans_q    <= HTRANS_IDLE;
            hwrite_q    <= 1'b0;
            hsize_q     <= 3'b000;
            hwdata_q    <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            haddr_q     <= haddr_d;
            htrans_q    <= htrans_d;
            hwrite_q    <= hwrite_d;
            hsize_q     <= hsize_d;
            hwdata_q    <= hwdata_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    assign HADDR     = haddr_q;
    assign HTRANS    = htrans_q;
    assign HWRITE    = hwrite_q;
    assign HSIZE     = hsize_q;
    assign HWDATA    = hwdata_q;
    assign HBURST    = HBURST_SINGLE;
    assign HPROT     = HPROT_VAL;
    assign HMASTLOCK = 1'b0;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_error = rsp_error_q;

`ifdef AHB_SINGLE_MASTER_ERRCNT_EN
    ahb_single_master_errcnt u_errcnt (
        .clk   (HCLK),
        .rst_n (HRESETn),
        .inc   (rsp_valid_q && rsp_error_q),
        .clr   (err_clr),
        .count (err_count)
    );
`endif

endmodule

// File: tb/tb_ahb_single_master.sv
// Directed bench for ahb_single_master; the slave side is driven by hand per cycle.
module tb_ahb_single_master;

    logic        HCLK;
    logic        HRESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [2:0]  cmd_size;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [1:0]  HRESP;
    logic [31:0] HRDATA;
`ifdef AHB_SINGLE_MASTER_ERRCNT_EN
    logic        err_clr;
    logic [15:0] err_count;
`endif

    int checks;
    int passed;

    ahb_single_master dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
`ifdef AHB_SINGLE_MASTER_ERRCNT_EN
        .err_clr   (err_clr),
        .err_count (err_count),
`endif
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_size  (cmd_size),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_error (rsp_error),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HPROT     (HPROT),
        .HMASTLOCK (HMASTLOCK),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_cmd(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                           input logic [31:0] wdata);
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_size  = size;
        cmd_wdata = wdata;
        cmd_valid = 1'b1;
    endtask

    task automatic test_reset;
        #2;
        checks++; if (HTRANS !== 2'b00) $display("FAIL reset_htrans: got %0h want 0", HTRANS); else passed++;
        checks++; if (HADDR !== 32'h0) $display("FAIL reset_haddr: got %h want 0", HADDR); else passed++;
        checks++; if (HWRITE !== 1'b0 || HSIZE !== 3'b000) $display("FAIL reset_hwrite_hsize: got %b/%0h want 0/0", HWRITE, HSIZE); else passed++;
        checks++; if (HWDATA !== 32'h0) $display("FAIL reset_hwdata: got %h want 0", HWDATA); else passed++;
        checks++; if (rsp_valid !== 1'b0 || rsp_error !== 1'b0 || rsp_rdata !== 32'h0)
            $display("FAIL reset_rsp: got v=%b e=%b d=%h want 0/0/0", rsp_valid, rsp_error, rsp_rdata); else passed++;
        checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); else passed++;
        checks++; if (HBURST !== 3'b000 || HPROT !== 4'b0011 || HMASTLOCK !== 1'b0)
            $display("FAIL reset_constants: got burst=%0h prot=%0h lock=%b want 0/3/0", HBURST, HPROT, HMASTLOCK); else passed++;
`ifdef AHB_SINGLE_MASTER_ERRCNT_EN
        checks++; if (err_count !== 16'h0) $display("FAIL reset_err_count: got %0d want 0", err_count); else passed++;
`endif
        @(posedge HCLK);
        @(posedge HCLK);
        #1 HRESETn = 1'b1;
        @(negedge HCLK);
        checks++; if (cmd_ready !== 1'b1 || HTRANS !== 2'b00)
            $display("FAIL post_reset_idle: got ready=%b htrans=%0h want 1/0", cmd_ready, HTRANS); else passed++;
    endtask

    task automatic test_write_zero_wait;
        @(posedge HCLK); #1;
        HREADY = 1'b1; HRESP = 2'b00;
        set_cmd(1'b1, 32'h2000_0010, 3'd2, 32'hDEAD_BEEF);
        @(negedge HCLK);
        checks++; if (cmd_ready !== 1'b1) $display("FAIL wr_ready_before: got %b want 1", cmd_ready); else passed++;
        @(posedge HCLK); #1 cmd_valid = 1'b0;
        @(negedge HCLK);
        checks++; if (HTRANS !== 2'b10 || HWRITE !== 1'b1 || HADDR !== 32'h2000_0010 || HSIZE !== 3'd2)
            $display("FAIL wr_addr_phase: got htrans=%0h hwrite=%b haddr=%h hsize=%0d want 2/1/20000010/2",
                     HTRANS, HWRITE, HADDR, HSIZE); else passed++;
        checks++; if (cmd_ready !== 1'b0) $display("FAIL wr_ready_busy: got %b want 0", cmd_ready); else passed++;
        @(posedge HCLK);
        @(negedge HCLK);
        checks++; if (HTRANS !== 2'b00 || HWDATA !== 32'hDEAD_BEEF)
            $display("FAIL wr_data_phase: got htrans=%0h hwdata=%h want 0/deadbeef", HTRANS, HWDATA); else passed++;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL wr_rsp_early: got %b want 0", rsp_valid); else passed++;
        @(posedge HCLK);
        @(negedge HCLK);
        checks++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b0)
            $display("FAIL wr_rsp: got v=%b e=%b want 1/0", rsp_valid, rsp_error); else passed++;
        checks++; if (cmd_ready !== 1'b0) $display("FAIL wr_ready_in_rsp: got %b want 0", cmd_ready); else passed++;
        @(posedge HCLK);
        @(negedge HCLK);
        checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1)
            $display("FAIL wr_after_rsp: got v=%b ready=%b want 0/1", rsp_valid, cmd_ready); else passed++;
        checks++; if (HWDATA !== 32'hDEAD_BEEF) $display("FAIL wr_hwdata_hold: got %h want deadbeef", HWDATA); else passed++;
    endtask

    task automatic test_read_wait;
        int lat;
        int pulses;
        bit htrans_bad;
        logic [31:0] rd;
        logic err;
        lat = 0; pulses = 0; htrans_bad = 1'b0; rd = '0; err = 1'b0;
        @(posedge HCLK); #1;
        HREADY = 1'b1; HRESP = 2'b00; HRDATA = 32'hBADB_AD00;
        set_cmd(1'b0, 32'h2000_0010, 3'd2, 32'h0);
        @(posedge HCLK); #1 cmd_valid = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            @(posedge HCLK); #1;
            HREADY = (n == 1 || n == 2) ? 1'b0 : 1'b1;
            HRDATA = (n >= 3) ? 32'h1234_5678 : 32'hBADB_AD00;
            @(negedge HCLK);
            if (HTRANS !== 2'b00) htrans_bad = 1'b1;
            if (rsp_valid === 1'b1) begin
                pulses++;
                if (lat == 0) begin
                    lat = n + 1;
                    rd  = rsp_rdata;
                    err = rsp_error;
                end
            end
        end
        checks++; if (lat != 5) $display("FAIL rd_latency: got %0d want 5", lat); else passed++;
        checks++; if (rd !== 32'h1234_5678) $display("FAIL rd_data: got %h want 12345678", rd); else passed++;
        checks++; if (err !== 1'b0 || pulses != 1) $display("FAIL rd_rsp: got err=%b pulses=%0d want 0/1", err, pulses); else passed++;
        checks++; if (htrans_bad) $display("FAIL rd_htrans_idle: got non-IDLE want IDLE during data phase"); else passed++;
    endtask

    task automatic test_error_resp;
        int lat;
        int pulses;
        bit htrans_bad;
        logic err;
        lat = 0; pulses = 0; htrans_bad = 1'b0; err = 1'b0;
        @(posedge HCLK); #1;
        HREADY = 1'b1; HRESP = 2'b00; HRDATA = 32'h0;
        set_cmd(1'b0, 32'hF000_0000, 3'd2, 32'h0);
        @(posedge HCLK); #1 cmd_valid = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            @(posedge HCLK); #1;
            HREADY = (n == 1) ? 1'b0 : 1'b1;
            HRESP  = (n <= 2) ? 2'b01 : 2'b00;
            @(negedge HCLK);
            if (HTRANS !== 2'b00) htrans_bad = 1'b1;
            if (rsp_valid === 1'b1) begin
                pulses++;
                if (lat == 0) begin
                    lat = n + 1;
                    err = rsp_error;
                end
            end
        end
        checks++; if (err !== 1'b1) $display("FAIL err_flag: got %b want 1", err); else passed++;
        checks++; if (pulses != 1) $display("FAIL err_pulses: got %0d want 1", pulses); else passed++;
        checks++; if (lat != 4) $display("FAIL err_latency: got %0d want 4", lat); else passed++;
        checks++; if (htrans_bad) $display("FAIL err_htrans_idle: got non-IDLE want IDLE"); else passed++;
    endtask

    task automatic test_addr_stall;
        int lat;
        int ready_hi;
        bit stable_bad;
        bit drained;
        lat = 0; ready_hi = 0; stable_bad = 1'b0; drained = 1'b0;
        @(posedge HCLK); #1;
        HREADY = 1'b1; HRESP = 2'b00;
        set_cmd(1'b1, 32'h3000_0004, 3'd1, 32'h0000_ABCD);
        @(posedge HCLK); #1 HREADY = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(posedge HCLK); #1;
            HREADY = (n >= 3) ? 1'b1 : 1'b0;
            @(negedge HCLK);
            if (n <= 3 && (HTRANS !== 2'b10 || HADDR !== 32'h3000_0004 || HWRITE !== 1'b1 || HSIZE !== 3'd1))
                stable_bad = 1'b1;
            if (cmd_ready === 1'b1) ready_hi++;
            if (rsp_valid === 1'b1) begin
                lat = n + 1;
                break;
            end
        end
        checks++; if (stable_bad) $display("FAIL stall_addr_stable: got changed addr phase want stable"); else passed++;
        checks++; if (lat != 6) $display("FAIL stall_latency: got %0d want 6", lat); else passed++;
        checks++; if (ready_hi != 0) $display("FAIL stall_no_reaccept: got %0d ready cycles want 0", ready_hi); else passed++;
        @(posedge HCLK);
        @(negedge HCLK);
        checks++; if (cmd_ready !== 1'b1) $display("FAIL stall_ready_after_rsp: got %b want 1", cmd_ready); else passed++;
        @(posedge HCLK); #1 cmd_valid = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge HCLK);
            if (rsp_valid === 1'b1) begin
                drained = 1'b1;
                break;
            end
        end
        checks++; if (!drained) $display("FAIL stall_second_xfer: got no rsp_valid want one"); else passed++;
    endtask

    task automatic test_reset_mid;
        int pulses;
        pulses = 0;
        @(posedge HCLK); #1;
        HREADY = 1'b1; HRESP = 2'b00;
        set_cmd(1'b1, 32'h4000_0008, 3'd2, 32'hCAFE_F00D);
        @(posedge HCLK); #1 cmd_valid = 1'b0;
        @(posedge HCLK); #1 HREADY = 1'b0;
        @(negedge HCLK);
        checks++; if (HWDATA !== 32'hCAFE_F00D || cmd_ready !== 1'b0)
            $display("FAIL rst_pre_data_phase: got hwdata=%h ready=%b want cafef00d/0", HWDATA, cmd_ready); else passed++;
        #2 HRESETn = 1'b0;
        #1;
        checks++; if (HTRANS !== 2'b00 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1)
            $display("FAIL rst_async_ctrl: got htrans=%0h v=%b ready=%b want 0/0/1", HTRANS, rsp_valid, cmd_ready); else passed++;
        checks++; if (HWDATA !== 32'h0 || HADDR !== 32'h0 || HWRITE !== 1'b0)
            $display("FAIL rst_async_bus: got hwdata=%h haddr=%h hwrite=%b want 0/0/0", HWDATA, HADDR, HWRITE); else passed++;
        HREADY = 1'b1;
        @(posedge HCLK);
        @(posedge HCLK);
        #1 HRESETn = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge HCLK);
            if (rsp_valid === 1'b1) pulses++;
        end
        checks++; if (pulses != 0 || cmd_ready !== 1'b1)
            $display("FAIL rst_no_rsp: got pulses=%0d ready=%b want 0/1", pulses, cmd_ready); else passed++;
    endtask

`ifdef AHB_SINGLE_MASTER_ERRCNT_EN
    task automatic run_err_xfer(input logic clr_on_rsp, output bit got);
        got = 1'b0;
        @(posedge HCLK); #1;
        HREADY = 1'b1; HRESP = 2'b00;
        set_cmd(1'b0, 32'hE000_0000, 3'd2, 32'h0);
        @(posedge HCLK); #1 cmd_valid = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            @(posedge HCLK); #1;
            HREADY  = (n == 1) ? 1'b0 : 1'b1;
            HRESP   = (n <= 2) ? 2'b01 : 2'b00;
            err_clr = 1'b0;
            @(negedge HCLK);
            if (rsp_valid === 1'b1 && !got) begin
                got = 1'b1;
                if (clr_on_rsp) err_clr = 1'b1;
            end
        end
        err_clr = 1'b0;
    endtask

    task automatic test_errcnt;
        bit g0, g1, g2, g3;
        run_err_xfer(1'b0, g0);
        run_err_xfer(1'b0, g1);
        run_err_xfer(1'b0, g2);
        @(negedge HCLK);
        checks++; if (!(g0 && g1 && g2)) $display("FAIL errcnt_rsp_seen: got %b%b%b want 111", g0, g1, g2); else passed++;
        checks++; if (err_count !== 16'd3) $display("FAIL errcnt_three: got %0d want 3", err_count); else passed++;
        run_err_xfer(1'b1, g3);
        @(negedge HCLK);
        checks++; if (!g3) $display("FAIL errcnt_fourth_rsp: got none want one"); else passed++;
        checks++; if (err_count !== 16'd0) $display("FAIL errcnt_clr_priority: got %0d want 0", err_count); else passed++;
    endtask
`endif

    initial begin
        checks    = 0;
        passed    = 0;
        HRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0;
        cmd_size  = 3'd0;
        cmd_wdata = 32'h0;
        HREADY    = 1'b1;
        HRESP     = 2'b00;
        HRDATA    = 32'h0;
`ifdef AHB_SINGLE_MASTER_ERRCNT_EN
        err_clr   = 1'b0;
`endif
        test_reset();
        test_write_zero_wait();
        test_read_wait();
        test_error_resp();
        test_addr_stall();
        test_reset_mid();
`ifdef AHB_SINGLE_MASTER_ERRCNT_EN
        test_errcnt();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
